kronos_operand_fwd: RTL and testbench

// - Execute-side consumer of the ID/EX hazard status. Holds one decoded instruction

---
 rtl/kronos_operand_fwd.sv | 149 ++++++++++++++
 tb/tb_kronos_operand_fwd.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kronos_operand_fwd.sv
// kronos_operand_fwd
// Holds one decoded instruction between decode and execute. Operands flagged as
// hazards wait for the next writeback result, which is substituted into every flagged
// operand at once (all flags name the same rd). The instruction is presented to
// execute only after all flags are resolved.
//
// Optional feature: define KRONOS_FWD_STALL_CNT_EN to add the saturating stall_cnt
// output, which counts cycles spent waiting on a hazard (cleared only by reset).
//
// Ports:
//   clk, rstz            clock, asynchronous active-low reset
//   flush                synchronous flush, drops the held instruction
//   dec_vld / dec_rdy    decode-side handshake
//   dec_op1..4           decoded operands
//   dec_hzd              {op_hazard, op4_hazard, op3_hazard, op2_hazard, op1_hazard}
//   fwd_vld / fwd_data   writeback result
//   ex_vld / ex_rdy      execute-side handshake
//   ex_op1..4            resolved operands
//   stall_cnt            hazard stall cycle count (KRONOS_FWD_STALL_CNT_EN only)

module kronos_operand_fwd #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rstz,
   input  logic                   flush,
   input  logic                   dec_vld,
   output logic                   dec_rdy,
   input  logic [XLEN-1:0]        dec_op1,
   input  logic [XLEN-1:0]        dec_op2,
   input  logic [XLEN-1:0]        dec_op3,
   input  logic [XLEN-1:0]        dec_op4,
   input  logic [4:0]             dec_hzd,
   input  logic                   fwd_vld,
   input  logic [XLEN-1:0]        fwd_data,
   output logic                   ex_vld,
   input  logic                   ex_rdy,
   output logic [XLEN-1:0]        ex_op1,
   output logic [XLEN-1:0]        ex_op2,
   output logic [XLEN-1:0]        ex_op3,
`ifdef KRONOS_FWD_STALL_CNT_EN
   output logic [XLEN-1:0]        ex_op4,
   output logic [STALL_CNT_W-1:0] stall_cnt
`else
   output logic [XLEN-1:0]        ex_op4
`endif
);

   typedef enum logic [1:0] {StEmpty, StWait, StReady} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] op_q [4];
   logic [XLEN-1:0] op_d [4];
   logic [XLEN-1:0] dec_op [4];
   logic [3:0]      hzd_q, hzd_d;
   logic            accept;
   logic            load;

   assign dec_op[0] = dec_op1;
   assign dec_op[1] = dec_op2;
   assign dec_op[2] = dec_op3;
   assign dec_op[3] = dec_op4;

   // The slot frees in the same cycle it issues, so a READY slot can take a new
   // instruction without a bubble.
   assign dec_rdy = !flush && ((state_q == StEmpty) || (state_q == StReady && ex_rdy));
   assign accept  = dec_vld && dec_rdy;

   always_comb begin
      state_d = state_q;
      hzd_d   = hzd_q;
      op_d    = op_q;
      load    = 1'b0;

      if (flush) begin
         state_d = StEmpty;
         hzd_d   = '0;
      end else begin
         unique case (state_q)
            StEmpty: load = accept;
            StWait: begin
               if (fwd_vld) begin
                  for (int i = 0; i < 4; i++) begin
                     if (hzd_q[i]) op_d[i] = fwd_data;
                  end
                  hzd_d   = '0;
                  state_d = StReady;
               end
            end
            StReady: begin
               if (ex_rdy) begin
                  if (dec_vld) load = 1'b1;
                  else         state_d = StEmpty;
               end
            end
            default: state_d = StEmpty;
         endcase

         if (load) begin
            // Entry bypass: a result arriving with the instruction resolves it at once.
            for (int i = 0; i < 4; i++) begin
               op_d[i] = (dec_hzd[4] && fwd_vld && dec_hzd[i]) ? fwd_data : dec_op[i];
            end
            if (dec_hzd[4] && !fwd_vld) begin
               hzd_d   = dec_hzd[3:0];
               state_d = StWait;
            end else begin
               hzd_d   = '0;
               state_d = StReady;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         state_q <= StEmpty;
         hzd_q   <= '0;
         for (int i = 0; i < 4; i++) op_q[i] <= '0;
      end else begin
         state_q <= state_d;
         hzd_q   <= hzd_d;
         for (int i = 0; i < 4; i++) op_q[i] <= op_d[i];
      end
   end

   assign ex_vld = (state_q == StReady);
   assign ex_op1 = op_q[0];
   assign ex_op2 = op_q[1];
   assign ex_op3 = op_q[2];
   assign ex_op4 = op_q[3];

`ifdef KRONOS_FWD_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_cnt_q;

   // Saturating; flush deliberately leaves it alone.
   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         stall_cnt_q <= '0;
      end else if (state_q == StWait && stall_cnt_q != '1) begin
         stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_kronos_operand_fwd.sv
// Self-checking bench for kronos_operand_fwd: a transaction-level model of the single
// instruction slot is compared against the DUT every cycle, plus literal spot checks.

module tb_kronos_operand_fwd;

   localparam int unsigned SW = 4;
   localparam int unsigned CNT_MAX = (1 << SW) - 1;

   logic        clk;
   logic        rstz;
   logic        flush;
   logic        dec_vld;
   logic        dec_rdy;
   logic [31:0] dop [4];
   logic [4:0]  dec_hzd;
   logic        fwd_vld;
   logic [31:0] fwd_data;
   logic        ex_vld;
   logic        ex_rdy;
   logic [31:0] ex_op1, ex_op2, ex_op3, ex_op4;
`ifdef KRONOS_FWD_STALL_CNT_EN
   logic [SW-1:0] stall_cnt;
`endif

   int n_chk;
   int n_fail;

   kronos_operand_fwd #(
      .XLEN        (32),
      .STALL_CNT_W (SW)
   ) dut (
      .clk       (clk),
      .rstz      (rstz),
      .flush     (flush),
      .dec_vld   (dec_vld),
      .dec_rdy   (dec_rdy),
      .dec_op1   (dop[0]),
      .dec_op2   (dop[1]),
      .dec_op3   (dop[2]),
      .dec_op4   (dop[3]),
      .dec_hzd   (dec_hzd),
      .fwd_vld   (fwd_vld),
      .fwd_data  (fwd_data),
      .ex_vld    (ex_vld),
      .ex_rdy    (ex_rdy),
      .ex_op1    (ex_op1),
      .ex_op2    (ex_op2),
      .ex_op3    (ex_op3),
`ifdef KRONOS_FWD_STALL_CNT_EN
      .ex_op4    (ex_op4),
      .stall_cnt (stall_cnt)
`else
      .ex_op4    (ex_op4)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] get_op(input int i);
      case (i)
         0:       return ex_op1;
         1:       return ex_op2;
         2:       return ex_op3;
         default: return ex_op4;
      endcase
   endfunction

   // Model: one slot that is either empty, holding an instruction awaiting a result,
   // or holding a resolved instruction.
   logic        m_held;
   logic        m_pend;
   logic [3:0]  m_mask;
   logic [31:0] m_ops [4];
   int          m_cnt;
   logic        exp_rdy;

   assign exp_rdy = !flush && (!m_held || (!m_pend && ex_rdy));

   always @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         m_held <= 1'b0;
         m_pend <= 1'b0;
         m_mask <= '0;
         m_cnt  <= 0;
      end else begin
         if (m_held && m_pend && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
         if (flush) begin
            m_held <= 1'b0;
            m_pend <= 1'b0;
         end else if (m_held && m_pend) begin
            if (fwd_vld) begin
               for (int i = 0; i < 4; i++) if (m_mask[i]) m_ops[i] <= fwd_data;
               m_pend <= 1'b0;
            end
         end else if (!m_held || ex_rdy) begin
            if (dec_vld) begin
               m_held <= 1'b1;
               m_mask <= dec_hzd[3:0];
               m_pend <= dec_hzd[4] && !fwd_vld;
               for (int i = 0; i < 4; i++)
                  m_ops[i] <= (dec_hzd[4] && fwd_vld && dec_hzd[i]) ? fwd_data : dop[i];
            end else begin
               m_held <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rstz) begin
         chk("ex_vld", {31'd0, ex_vld}, {31'd0, m_held && !m_pend});
         chk("dec_rdy", {31'd0, dec_rdy}, {31'd0, exp_rdy});
         if (m_held && !m_pend) begin
            for (int i = 0; i < 4; i++) chk("ex_op", get_op(i), m_ops[i]);
         end
`ifdef KRONOS_FWD_STALL_CNT_EN
         chk("stall_cnt", {28'd0, stall_cnt}, m_cnt);
`endif
      end
   end

   task automatic set_ops(input logic [31:0] a, b, c, d);
      dop[0] = a; dop[1] = b; dop[2] = c; dop[3] = d;
   endtask

   task automatic step(input logic dv, input logic [4:0] hz, input logic fv,
                       input logic [31:0] fd, input logic er, input logic fl);
      dec_vld = dv; dec_hzd = hz; fwd_vld = fv; fwd_data = fd; ex_rdy = er; flush = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rstz = 1'b0;
      flush = 1'b0; dec_vld = 1'b0; dec_hzd = '0; fwd_vld = 1'b0; fwd_data = '0;
      ex_rdy = 1'b0;
      set_ops(0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ex_vld", {31'd0, ex_vld}, 32'd0);
      chk("reset_ex_op1", ex_op1, 32'd0);
      chk("reset_ex_op4", ex_op4, 32'd0);
      chk("reset_dec_rdy", {31'd0, dec_rdy}, 32'd1);
      rstz = 1'b1;

      // No hazard, back-to-back stream
      set_ops(32'h11, 32'h12, 32'h13, 32'h14);
      step(1, 5'b00000, 0, 0, 1, 0);
      chk("nohzd_vld", {31'd0, ex_vld}, 32'd1);
      chk("nohzd_op1", ex_op1, 32'h11);
      set_ops(32'h21, 32'h22, 32'h23, 32'h24);
      step(1, 5'b00000, 0, 0, 1, 0);
      chk("stream_op1", ex_op1, 32'h21);
      step(0, 5'b00000, 0, 0, 1, 0);
      chk("stream_drain", {31'd0, ex_vld}, 32'd0);

      // Hazard wait: result arrives three cycles after accept
      set_ops(32'hDEAD, 32'h2, 32'h3, 32'h4);
      step(1, 5'b10001, 0, 0, 1, 0);
      step(0, 5'b00000, 0, 0, 1, 0);
      step(0, 5'b00000, 0, 0, 1, 0);
      chk("wait_vld0", {31'd0, ex_vld}, 32'd0);
      step(0, 5'b00000, 1, 32'hBEEF, 0, 0);
      chk("wait_vld1", {31'd0, ex_vld}, 32'd1);
      chk("wait_op1", ex_op1, 32'hBEEF);
      chk("wait_op2", ex_op2, 32'h2);
      chk("wait_op4", ex_op4, 32'h4);
`ifdef KRONOS_FWD_STALL_CNT_EN
      chk("wait_stall", {28'd0, stall_cnt}, 32'd3);
`endif

      // Backpressure with stray results
      for (int k = 0; k < 4; k++) begin
         step(1, 5'b10001, 1, 32'h77 + k, 0, 0);
         chk("bp_dec_rdy", {31'd0, dec_rdy}, 32'd0);
         chk("bp_op1", ex_op1, 32'hBEEF);
      end
      step(0, 5'b00000, 0, 0, 1, 0);

      // Entry bypass
      set_ops(32'h1, 32'h2, 32'h3, 32'h4);
      step(1, 5'b11010, 1, 32'h55, 0, 0);
      chk("byp_vld", {31'd0, ex_vld}, 32'd1);
      chk("byp_op1", ex_op1, 32'h1);
      chk("byp_op2", ex_op2, 32'h55);
      chk("byp_op3", ex_op3, 32'h3);
      chk("byp_op4", ex_op4, 32'h55);
      step(0, 5'b00000, 0, 0, 1, 0);

      // Flush in WAIT coincident with a result
      set_ops(32'hA, 32'hB, 32'hC, 32'hD);
      step(1, 5'b10001, 0, 0, 0, 0);
      step(1, 5'b00000, 1, 32'h99, 0, 1);
      chk("flush_vld", {31'd0, ex_vld}, 32'd0);
      step(0, 5'b00000, 1, 32'h66, 0, 0);
      chk("flush_ign_fwd", {31'd0, ex_vld}, 32'd0);
      chk("flush_dec_rdy", {31'd0, dec_rdy}, 32'd1);

      // Malformed: op_hazard with no operand flags
      set_ops(32'h5, 32'h6, 32'h7, 32'h8);
      step(1, 5'b10000, 0, 0, 0, 0);
      step(0, 5'b00000, 0, 0, 0, 0);
      chk("malf_wait", {31'd0, ex_vld}, 32'd0);
      step(0, 5'b00000, 1, 32'hFF, 0, 0);
      chk("malf_vld", {31'd0, ex_vld}, 32'd1);
      chk("malf_op1", ex_op1, 32'h5);
      step(0, 5'b00000, 0, 0, 1, 0);

      // Asynchronous reset while READY
      set_ops(32'h31, 32'h32, 32'h33, 32'h34);
      step(1, 5'b00000, 0, 0, 0, 0);
      chk("pre_rst_vld", {31'd0, ex_vld}, 32'd1);
      rstz = 1'b0;
      #1;
      chk("async_rst_vld", {31'd0, ex_vld}, 32'd0);
      chk("async_rst_op1", ex_op1, 32'd0);
      rstz = 1'b1;
      step(0, 5'b00000, 0, 0, 0, 0);

`ifdef KRONOS_FWD_STALL_CNT_EN
      // Counter saturation over a long wait
      set_ops(32'h1, 32'h2, 32'h3, 32'h4);
      step(1, 5'b10001, 0, 0, 0, 0);
      for (int k = 0; k < 20; k++) step(0, 5'b00000, 0, 0, 0, 0);
      chk("stall_sat", {28'd0, stall_cnt}, 32'd15);
      step(0, 5'b00000, 0, 0, 0, 1);
`endif

      step(0, 5'b00000, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
